// File: rtl/snitch_event_counters_pkg.sv
// Shared register offsets and configuration record for the per-core event counter bank.
// No logic, no latency; nothing here applies backpressure.
package snitch_event_counters_pkg;

  localparam int unsigned CtrlOffset    = 32'h000;
  localparam int unsigned EnOffset      = 32'h004;
  localparam int unsigned OvfOffset     = 32'h008;
  localparam int unsigned CounterBase   = 32'h100;
  localparam int unsigned CounterStride = 8;

  typedef struct packed {
    int unsigned nr_cores;
    int unsigned nr_events;
    int unsigned counter_width;
    bit          saturate;
  } event_counter_cfg_t;

  function automatic int unsigned nr_counters(event_counter_cfg_t cfg);
    return cfg.nr_cores * cfg.nr_events;
  endfunction

endpackage

// File: rtl/snitch_event_counter.sv
// One wide event counter: clear > low/high load > increment, wrap or saturate on overflow.
// Value updates one cycle after the strobe; overflow_o is a same-cycle pulse; no backpressure.
module snitch_event_counter #(
  parameter int unsigned Width    = 48,
  parameter bit          Saturate = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             load_lo_i,
  input  logic             load_hi_i,
  input  logic [31:0]      wdata_i,
  output logic [Width-1:0] value_o,
  output logic             overflow_o
);

  logic [Width-1:0] cnt_q, cnt_d;
  logic             at_max;
  logic             inc_ok;

  assign at_max = &cnt_q;
  // An increment that loses to a clear or load is dropped and must not flag overflow.
  assign inc_ok = en_i & ~clr_i & ~load_lo_i & ~load_hi_i;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_lo_i) begin
      cnt_d[31:0] = wdata_i;
    end else if (load_hi_i) begin
      cnt_d[Width-1:32] = wdata_i[Width-33:0];
    end else if (en_i) begin
      if (!(Saturate && at_max)) begin
        cnt_d = cnt_q + {{(Width-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o    = cnt_q;
  assign overflow_o = inc_ok & at_max;

endmodule

// File: rtl/snitch_event_counters.sv
// Bank of per-(core,event) counters behind a 32-bit register port with a shared high-word shadow.
// Response exactly one cycle after each request; reg_ready_o is always 1, no response backpressure.
module snitch_event_counters
  import snitch_event_counters_pkg::*;
#(
  parameter int unsigned NrCores      = 4,
  parameter int unsigned NrEvents     = 4,
  parameter int unsigned CounterWidth = 48,
  parameter bit          Saturate     = 1'b0,
  parameter int unsigned AddrWidth    = 12
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NrCores*NrEvents-1:0]  events_i,
  input  logic                         reg_valid_i,
  output logic                         reg_ready_o,
  input  logic                         reg_write_i,
  input  logic [AddrWidth-1:0]         reg_addr_i,
  input  logic [31:0]                  reg_wdata_i,
  output logic                         rsp_valid_o,
  output logic [31:0]                  rsp_rdata_o,
  output logic                         rsp_error_o
);

  localparam event_counter_cfg_t Cfg = '{
    nr_cores:      NrCores,
    nr_events:     NrEvents,
    counter_width: CounterWidth,
    saturate:      Saturate
  };
  localparam int unsigned N  = nr_counters(Cfg);
  localparam int unsigned CW = Cfg.counter_width;
  localparam int unsigned SW = CW - 32;

  logic              wr, rd;
  logic              is_ctrl, is_en, is_ovf, in_ctr, is_lo, is_hi, hit;
  logic [AddrWidth-1:0] ctr_off;
  logic [N-1:0]      ctr_sel, load_lo, load_hi, cnt_en, ovf_pulse;
  logic              clr;
  logic [CW-1:0]     cnt_value [N];

  logic              ctrl_en_q;
  logic [N-1:0]      en_mask_q, ovf_q;
  logic [SW-1:0]     shadow_q, shadow_nxt;
  logic [31:0]       rdata_d;
  logic              rsp_valid_q, rsp_error_q;
  logic [31:0]       rsp_rdata_q;

  assign reg_ready_o = 1'b1;
  assign wr = reg_valid_i & reg_write_i;
  assign rd = reg_valid_i & ~reg_write_i;

  assign is_ctrl = reg_addr_i == AddrWidth'(CtrlOffset);
  assign is_en   = reg_addr_i == AddrWidth'(EnOffset);
  assign is_ovf  = reg_addr_i == AddrWidth'(OvfOffset);
  assign ctr_off = reg_addr_i - AddrWidth'(CounterBase);
  // Below-base addresses wrap ctr_off to a large value, so the >= guard is what rejects them.
  assign in_ctr  = (reg_addr_i >= AddrWidth'(CounterBase)) &&
                   (ctr_off < AddrWidth'(CounterStride * N)) &&
                   (ctr_off[1:0] == 2'b00);
  assign is_lo   = in_ctr & ~ctr_off[2];
  assign is_hi   = in_ctr &  ctr_off[2];
  assign hit     = is_ctrl | is_en | is_ovf | in_ctr;
  assign clr     = wr & is_ctrl & reg_wdata_i[1];

  always_comb begin
    ctr_sel = '0;
    for (int i = 0; i < N; i++) begin
      ctr_sel[i] = in_ctr && (ctr_off[AddrWidth-1:3] == (AddrWidth-3)'(i));
    end
  end

  assign load_lo = {N{wr & is_lo}} & ctr_sel;
  assign load_hi = {N{wr & is_hi}} & ctr_sel;
  assign cnt_en  = events_i & en_mask_q & {N{ctrl_en_q}};

  for (genvar g = 0; g < N; g++) begin : gen_counter
    snitch_event_counter #(
      .Width    (CW),
      .Saturate (Cfg.saturate)
    ) i_counter (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clr_i      (clr),
      .en_i       (cnt_en[g]),
      .load_lo_i  (load_lo[g]),
      .load_hi_i  (load_hi[g]),
      .wdata_i    (reg_wdata_i),
      .value_o    (cnt_value[g]),
      .overflow_o (ovf_pulse[g])
    );
  end

  // Read data is the pre-increment counter value; a low-word read also captures its upper bits.
  always_comb begin
    rdata_d    = '0;
    shadow_nxt = shadow_q;
    if (is_ctrl) begin
      rdata_d[0] = ctrl_en_q;
    end else if (is_en) begin
      rdata_d[N-1:0] = en_mask_q;
    end else if (is_ovf) begin
      rdata_d[N-1:0] = ovf_q;
    end else if (is_hi) begin
      rdata_d[SW-1:0] = shadow_q;
    end
    for (int i = 0; i < N; i++) begin
      if (is_lo && ctr_sel[i]) begin
        rdata_d    = cnt_value[i][31:0];
        shadow_nxt = cnt_value[i][CW-1:32];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_en_q <= 1'b0;
      en_mask_q <= '1;
      ovf_q     <= '0;
      shadow_q  <= '0;
    end else begin
      if (wr && is_ctrl) ctrl_en_q <= reg_wdata_i[0];
      if (wr && is_en)   en_mask_q <= reg_wdata_i[N-1:0];
      // Set after clear so a same-cycle overflow survives the W1C.
      ovf_q <= (ovf_q & ~({N{wr & is_ovf}} & reg_wdata_i[N-1:0])) | ovf_pulse;
      if (clr) begin
        shadow_q <= '0;
      end else if (rd && is_lo) begin
        shadow_q <= shadow_nxt;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= reg_valid_i;
      rsp_error_q <= reg_valid_i & ~hit;
      rsp_rdata_q <= (rd && hit) ? rdata_d : 32'h0;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_error_o = rsp_error_q;

endmodule
